fat32_dir_entry_scanner: RTL and testbench

Read-side counterpart of the FAT32 write path: scans one streamed 512-byte root-directory sector, byte by byte as the SD read engine delivers it, for a short-name (8.3) entry matching a compile-time file name. On a match it returns the file's start cluster and size. It also reports whether the directory ended in this sector or the controller must load the next sector. It sits between the SD sector reader and the file-locate controller that already consumes the MBR/BPR-derived root directory sector and cluster geometry.

---
 rtl/fat32_pkg.sv | 33 +++
 rtl/fat32_dir_entry_scanner_dir_name_matcher.sv | 73 +++++++
 rtl/fat32_dir_entry_scanner.sv | 190 +++++++++++++++++++
 tb/tb_fat32_dir_entry_scanner.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fat32_pkg.sv
// ---------------------------------------------------------------------------
// fat32_pkg
// Shared constants for the FAT32 directory-entry read path: 32-byte short-name
// entry layout, entry markers, attribute bits and the scanner state encoding.
// ---------------------------------------------------------------------------
package fat32_pkg;

    localparam int DIR_ENTRY_BYTES = 32;
    localparam int NAME_BYTES      = 11;

    // Field offsets inside one 32-byte short-name entry
    localparam logic [4:0] OFF_NAME    = 5'd0;
    localparam logic [4:0] OFF_ATTR    = 5'd11;
    localparam logic [4:0] OFF_CLUS_HI = 5'd20;
    localparam logic [4:0] OFF_CLUS_LO = 5'd26;
    localparam logic [4:0] OFF_SIZE    = 5'd28;

    // First-byte markers
    localparam logic [7:0] MARK_END     = 8'h00;
    localparam logic [7:0] MARK_DELETED = 8'hE5;

    // Attribute values / bits
    localparam logic [7:0] ATTR_LFN    = 8'h0F;
    localparam logic [7:0] ATTR_VOLUME = 8'h08;
    localparam logic [7:0] ATTR_DIR    = 8'h10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/fat32_dir_entry_scanner_dir_name_matcher.sv
// ---------------------------------------------------------------------------
// dir_name_matcher
// Compares the 11 name bytes of a directory entry against SEARCH_NAME one byte
// at a time and accumulates the result across the entry.
//
// Ports:
//   Clock       in   system clock
//   sys_rst_n   in   asynchronous active-low reset
//   clear       in   drop any accumulated result (new scan)
//   byte_en     in   byte_data/byte_off belong to an accepted in-order byte
//   byte_off    in   offset of the byte within its 32-byte entry
//   byte_data   in   sector byte
//   name_match  out  all name bytes seen so far in this entry matched
//
// Build option: DIR_SCAN_CASE_FOLD_EN folds incoming 'a'..'z' to upper case
// before the compare; without it the compare is an exact byte match.
// ---------------------------------------------------------------------------
module dir_name_matcher
    import fat32_pkg::*;
#(
    parameter logic [8*NAME_BYTES-1:0] SEARCH_NAME = "SAVEDATADAT"
) (
    input  logic       Clock,
    input  logic       sys_rst_n,
    input  logic       clear,
    input  logic       byte_en,
    input  logic [4:0] byte_off,
    input  logic [7:0] byte_data,
    output logic       name_match
);

    logic [7:0] ref_byte;
    logic [7:0] cmp_byte;
    logic       byte_eq;

    function automatic logic [7:0] fold_byte(input logic [7:0] b);
`ifdef DIR_SCAN_CASE_FOLD_EN
        if (b >= 8'h61 && b <= 8'h7A) begin
            return b - 8'h20;
        end
`endif
        return b;
    endfunction

    // Name byte 0 sits in the MSBs of SEARCH_NAME
    always_comb begin
        ref_byte = '0;
        for (int i = 0; i < NAME_BYTES; i++) begin
            if (byte_off == 5'(i)) begin
                ref_byte = SEARCH_NAME[8*(NAME_BYTES-1-i) +: 8];
            end
        end
    end

    assign cmp_byte = fold_byte(byte_data);
    assign byte_eq  = (cmp_byte == ref_byte);

    // Offset 0 restarts the accumulation for each new entry
    always_ff @(posedge Clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            name_match <= 1'b0;
        end else if (clear) begin
            name_match <= 1'b0;
        end else if (byte_en) begin
            if (byte_off == OFF_NAME) begin
                name_match <= byte_eq;
            end else if (byte_off < 5'(NAME_BYTES)) begin
                name_match <= name_match & byte_eq;
            end
        end
    end

endmodule

// File: rtl/fat32_dir_entry_scanner.sv
// ---------------------------------------------------------------------------
// fat32_dir_entry_scanner
// Scans one streamed root-directory sector for a short-name entry equal to
// SEARCH_NAME and reports its start cluster and size, or whether the directory
// ended in this sector, or that the byte stream was out of order.
//
// Ports:
//   Clock          in   system clock (rising edge)
//   sys_rst_n      in   asynchronous active-low reset
//   start          in   pulse: arm (or abort and re-arm) a sector scan
//   byte_valid     in   byte_addr/byte_data valid
//   byte_addr[8:0] in   byte offset within sector
//   byte_data[7:0] in   sector byte
//   busy           out  scan armed and not finished
//   done           out  result valid, held until next start
//   found          out  matching entry located
//   end_of_dir     out  0x00 end marker hit before a match
//   seq_error      out  byte_addr differed from the expected offset
//   entry_index    out  slot of the match or end marker
//   start_cluster  out  {hi16, lo16} of the matching entry
//   file_size      out  size of the matching entry
//
// Build option: DIR_SCAN_CASE_FOLD_EN (see dir_name_matcher).
// ---------------------------------------------------------------------------
module fat32_dir_entry_scanner
    import fat32_pkg::*;
#(
    parameter logic [8*NAME_BYTES-1:0] SEARCH_NAME  = "SAVEDATADAT",
    parameter int                      SECTOR_BYTES = 512
) (
    input  logic        Clock,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [8:0]  byte_addr,
    input  logic [7:0]  byte_data,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic        end_of_dir,
    output logic        seq_error,
    output logic [3:0]  entry_index,
    output logic [31:0] start_cluster,
    output logic [31:0] file_size
);

    localparam logic [8:0] LAST_ADDR = 9'(SECTOR_BYTES - 1);
    localparam logic [4:0] OFF_LAST  = 5'(DIR_ENTRY_BYTES - 1);

    scan_state_t state_q, state_d;

    logic [8:0]  exp_addr_q;
    logic        skip_q;
    logic        name_match;
    logic [15:0] clus_hi_sh;
    logic [15:0] clus_lo_sh;
    logic [23:0] size_sh;

    logic [4:0]  off;
    logic [3:0]  slot;
    logic        accept;
    logic        in_seq;
    logic        ev_seq;
    logic        ev_end;
    logic        ev_found;
    logic        ev_last;

    assign off  = byte_addr[4:0];
    assign slot = byte_addr[8:5];

    // start wins over a same-cycle byte, which is then dropped
    assign accept   = (state_q == ST_SCAN) && byte_valid && !start;
    assign in_seq   = accept && (byte_addr == exp_addr_q);
    assign ev_seq   = accept && (byte_addr != exp_addr_q);
    assign ev_end   = in_seq && (off == OFF_NAME) && (byte_data == MARK_END);
    assign ev_found = in_seq && (off == OFF_LAST) && name_match && !skip_q;
    assign ev_last  = in_seq && (byte_addr == LAST_ADDR) && !ev_found;

    dir_name_matcher #(
        .SEARCH_NAME(SEARCH_NAME)
    ) u_name_matcher (
        .Clock      (Clock),
        .sys_rst_n  (sys_rst_n),
        .clear      (start),
        .byte_en    (in_seq),
        .byte_off   (off),
        .byte_data  (byte_data),
        .name_match (name_match)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_SCAN;
            ST_SCAN: begin
                if (start) begin
                    state_d = ST_SCAN;
                end else if (ev_seq || ev_end || ev_found || ev_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: if (start) state_d = ST_SCAN;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign busy = (state_q == ST_SCAN);
    assign done = (state_q == ST_DONE);

    // Expected address and per-entry skip flag
    always_ff @(posedge Clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            exp_addr_q <= '0;
            skip_q     <= 1'b0;
        end else if (start) begin
            exp_addr_q <= '0;
            skip_q     <= 1'b0;
        end else if (in_seq) begin
            exp_addr_q <= exp_addr_q + 9'd1;
            if (off == OFF_NAME) begin
                skip_q <= (byte_data == MARK_DELETED);
            end else if (off == OFF_ATTR) begin
                if ((byte_data == ATTR_LFN) ||
                    ((byte_data & ATTR_VOLUME) != 8'h00) ||
                    ((byte_data & ATTR_DIR) != 8'h00)) begin
                    skip_q <= 1'b1;
                end
            end
        end
    end

    // Shadow copies of the current entry's fields; only published on a match
    always_ff @(posedge Clock) begin
        if (start) begin
            clus_hi_sh <= '0;
            clus_lo_sh <= '0;
            size_sh    <= '0;
        end else if (in_seq) begin
            case (off)
                OFF_CLUS_HI:         clus_hi_sh[7:0]   <= byte_data;
                OFF_CLUS_HI + 5'd1:  clus_hi_sh[15:8]  <= byte_data;
                OFF_CLUS_LO:         clus_lo_sh[7:0]   <= byte_data;
                OFF_CLUS_LO + 5'd1:  clus_lo_sh[15:8]  <= byte_data;
                OFF_SIZE:            size_sh[7:0]      <= byte_data;
                OFF_SIZE + 5'd1:     size_sh[15:8]     <= byte_data;
                OFF_SIZE + 5'd2:     size_sh[23:16]    <= byte_data;
                default: ;
            endcase
        end
    end

    // Published result; size byte 31 arrives with the deciding byte itself
    always_ff @(posedge Clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            found         <= 1'b0;
            end_of_dir    <= 1'b0;
            seq_error     <= 1'b0;
            entry_index   <= '0;
            start_cluster <= '0;
            file_size     <= '0;
        end else if (start) begin
            found         <= 1'b0;
            end_of_dir    <= 1'b0;
            seq_error     <= 1'b0;
            entry_index   <= '0;
            start_cluster <= '0;
            file_size     <= '0;
        end else if (ev_seq) begin
            seq_error <= 1'b1;
            found     <= 1'b0;
        end else if (ev_end) begin
            end_of_dir  <= 1'b1;
            entry_index <= slot;
        end else if (ev_found) begin
            found         <= 1'b1;
            entry_index   <= slot;
            start_cluster <= {clus_hi_sh, clus_lo_sh};
            file_size     <= {byte_data, size_sh};
        end
    end

endmodule

// File: tb/tb_fat32_dir_entry_scanner.sv
module tb_fat32_dir_entry_scanner;

    localparam logic [87:0] NAME = "SAVEDATADAT";

    logic        Clock = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [8:0]  byte_addr = '0;
    logic [7:0]  byte_data = '0;
    logic        busy, done, found, end_of_dir, seq_error;
    logic [3:0]  entry_index;
    logic [31:0] start_cluster, file_size;

    always #5 Clock = ~Clock;

    fat32_dir_entry_scanner dut (
        .Clock         (Clock),
        .sys_rst_n     (sys_rst_n),
        .start         (start),
        .byte_valid    (byte_valid),
        .byte_addr     (byte_addr),
        .byte_data     (byte_data),
        .busy          (busy),
        .done          (done),
        .found         (found),
        .end_of_dir    (end_of_dir),
        .seq_error     (seq_error),
        .entry_index   (entry_index),
        .start_cluster (start_cluster),
        .file_size     (file_size)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // Expected outputs, updated by the driver from the model
    logic        e_busy = 0, e_done = 0, e_found = 0, e_eod = 0, e_seq = 0;
    logic [3:0]  e_idx = 0;
    logic [31:0] e_sc = 0, e_fs = 0;

    logic [7:0]  sec [512];
    bit          pend_start = 0, pend_dec = 0;
    int          m_kind, m_pos, m_idx;
    logic [31:0] m_sc, m_fs;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (chk_en) begin
            chk("busy",          32'(busy),        32'(e_busy));
            chk("done",          32'(done),        32'(e_done));
            chk("found",         32'(found),       32'(e_found));
            chk("end_of_dir",    32'(end_of_dir),  32'(e_eod));
            chk("seq_error",     32'(seq_error),   32'(e_seq));
            chk("entry_index",   32'(entry_index), 32'(e_idx));
            chk("start_cluster", start_cluster,    e_sc);
            chk("file_size",     file_size,        e_fs);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ model
    function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef DIR_SCAN_CASE_FOLD_EN
        if (b >= "a" && b <= "z") return b - 8'd32;
`endif
        return b;
    endfunction

    function automatic logic [7:0] nm_byte(input logic [87:0] n, input int i);
        return n[87-8*i -: 8];
    endfunction

    function automatic bit name_is_match(input int base);
        for (int i = 0; i < 11; i++)
            if (fold(sec[base+i]) != nm_byte(NAME, i)) return 0;
        return 1;
    endfunction

    // kind: 0 no match in sector, 1 found, 2 end marker, 3 sequence error
    // pos: stream position of the deciding byte
    task automatic model(input int jump, output int kind, output int pos, output int idx,
                         output logic [31:0] sc, output logic [31:0] fs);
        logic [7:0] attr;
        kind = 0; pos = 511; idx = 0; sc = 0; fs = 0;
        for (int s = 0; s < 16; s++) begin
            int base = 32 * s;
            if (jump >= 0 && jump <= base) begin kind = 3; pos = jump; return; end
            if (sec[base] == 8'h00) begin kind = 2; pos = base; idx = s; return; end
            if (jump >= 0 && jump <= base + 31) begin kind = 3; pos = jump; return; end
            attr = sec[base+11];
            if (sec[base] != 8'hE5 && attr != 8'h0F && !attr[3] && !attr[4] && name_is_match(base)) begin
                kind = 1; pos = base + 31; idx = s;
                sc = {sec[base+21], sec[base+20], sec[base+27], sec[base+26]};
                fs = {sec[base+31], sec[base+30], sec[base+29], sec[base+28]};
                return;
            end
        end
    endtask

    // ------------------------------------------------------------ sector builders
    task automatic fill_filler();
        for (int s = 0; s < 16; s++) begin
            for (int i = 0; i < 32; i++) sec[32*s+i] = 8'($urandom);
            sec[32*s]    = 8'(8'h41 + $urandom_range(17));  // 'A'..'R', never a match
            sec[32*s+11] = 8'h20;
        end
    endtask

    task automatic put_entry(input int slot, input logic [87:0] nm, input logic [7:0] attr,
                             input logic [31:0] clus, input logic [31:0] size);
        int b = 32 * slot;
        for (int i = 0; i < 11; i++) sec[b+i] = nm_byte(nm, i);
        sec[b+11] = attr;
        sec[b+20] = clus[23:16]; sec[b+21] = clus[31:24];
        sec[b+26] = clus[7:0];   sec[b+27] = clus[15:8];
        sec[b+28] = size[7:0];   sec[b+29] = size[15:8];
        sec[b+30] = size[23:16]; sec[b+31] = size[31:24];
    endtask

    // ------------------------------------------------------------ driver
    task automatic clear_exp();
        e_busy = 0; e_done = 0; e_found = 0; e_eod = 0; e_seq = 0;
        e_idx = 0; e_sc = 0; e_fs = 0;
    endtask

    task automatic step();
        @(posedge Clock);
        if (pend_start) begin
            clear_exp();
            e_busy = 1;
            pend_start = 0;
        end
        if (pend_dec) begin
            e_busy = 0; e_done = 1;
            e_found = (m_kind == 1);
            e_eod   = (m_kind == 2);
            e_seq   = (m_kind == 3);
            e_idx   = (m_kind == 1 || m_kind == 2) ? 4'(m_idx) : 4'd0;
            e_sc    = (m_kind == 1) ? m_sc : 32'd0;
            e_fs    = (m_kind == 1) ? m_fs : 32'd0;
            pend_dec = 0;
        end
        #1;
    endtask

    task automatic run_scan(input int jump_at, input int rst_at, input int abort_at, input int gap_pct);
        model(jump_at, m_kind, m_pos, m_idx, m_sc, m_fs);
        start = 1;
        byte_valid = 1'($urandom_range(1));   // must be ignored alongside start
        byte_addr = '0;
        byte_data = 8'h00;
        pend_start = 1;
        step();
        start = 0;
        byte_valid = 0;
        for (int k = 0; k < 512; k++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                byte_valid = 0; byte_addr = 9'($urandom); byte_data = 8'($urandom);
                step();
            end
            if (k == rst_at) begin
                byte_valid = 0;
                sys_rst_n = 0;
                clear_exp();
                repeat (3) step();
                sys_rst_n = 1;
                step();
                return;
            end
            if (k == abort_at) return;
            byte_valid = 1;
            byte_addr = 9'((k == jump_at) ? k + 1 : k);
            byte_data = sec[k];
            if (k == m_pos) pend_dec = 1;
            step();
            if (k == m_pos) begin
                // trailing bytes after the decision must not disturb the result
                for (int x = 1; x <= 2; x++) begin
                    byte_addr = 9'(k + x); byte_data = 8'h00;
                    step();
                end
                break;
            end
        end
        byte_valid = 0;
        step();
        step();
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        clear_exp();
        chk_en = 1;
        repeat (3) step();
        sys_rst_n = 1;
        step();
        chk("reset_done", 32'(done), 32'd0);

        // Match in slot 2
        fill_filler();
        put_entry(2, NAME, 8'h20, 32'h0000_0005, 32'h0000_1000);
        run_scan(-1, -1, -1, 0);
        chk("t1_model_pos", m_pos, 32'd95);
        chk("t1_found", 32'(found), 32'd1);
        chk("t1_index", 32'(entry_index), 32'd2);
        chk("t1_cluster", start_cluster, 32'd5);
        chk("t1_size", file_size, 32'd4096);

        // Deleted copy, LFN copy, end marker in slot 3
        fill_filler();
        put_entry(0, NAME, 8'h20, 32'h1234_5678, 32'h99);
        sec[0] = 8'hE5;
        put_entry(1, NAME, 8'h0F, 32'h1, 32'h2);
        sec[96] = 8'h00;
        run_scan(-1, -1, -1, 15);
        chk("t2_model_pos", m_pos, 32'd96);
        chk("t2_found", 32'(found), 32'd0);
        chk("t2_eod", 32'(end_of_dir), 32'd1);
        chk("t2_index", 32'(entry_index), 32'd3);

        // Full sector, nothing matches
        fill_filler();
        run_scan(-1, -1, -1, 10);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_found", 32'(found), 32'd0);
        chk("t3_eod", 32'(end_of_dir), 32'd0);

        // Address jump 40 -> 42
        fill_filler();
        put_entry(5, NAME, 8'h20, 32'h7, 32'h8);
        run_scan(41, -1, -1, 0);
        chk("t4_seq", 32'(seq_error), 32'd1);
        chk("t4_found", 32'(found), 32'd0);

        // Reset mid-scan, then a clean matching scan
        fill_filler();
        put_entry(3, NAME, 8'h20, 32'h0003_0009, 32'h0001_0203);
        run_scan(-1, 50, -1, 10);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        run_scan(-1, -1, -1, 10);
        chk("t5_found", 32'(found), 32'd1);
        chk("t5_cluster", start_cluster, 32'h0003_0009);

        // Abort by a new start mid-scan
        run_scan(-1, -1, 30, 10);
        fill_filler();
        put_entry(7, NAME, 8'h21, 32'hABCD_0001, 32'h55);
        run_scan(-1, -1, -1, 10);
        chk("t6_index", 32'(entry_index), 32'd7);

        // Lowercase name
        fill_filler();
        put_entry(4, "savedatadat", 8'h20, 32'h11, 32'h22);
        run_scan(-1, -1, -1, 5);
`ifdef DIR_SCAN_CASE_FOLD_EN
        chk("t7_lower_found", 32'(found), 32'd1);
`else
        chk("t7_lower_found", 32'(found), 32'd0);
`endif

        // Randomized sectors
        for (int n = 0; n < 20; n++) begin
            int jump;
            logic [7:0] attrs [6];
            attrs = '{8'h20, 8'h01, 8'h0F, 8'h08, 8'h10, 8'h21};
            fill_filler();
            for (int s = 0; s < 16; s++) begin
                int r = int'($urandom_range(99));
                if (r < 4) begin
                    sec[32*s] = 8'h00;
                end else if (r < 16) begin
                    put_entry(s, NAME, attrs[$urandom_range(5)], $urandom, $urandom);
                end else if (r < 22) begin
                    put_entry(s, NAME, 8'h20, $urandom, $urandom);
                    sec[32*s] = 8'hE5;
                end else if (r < 26) begin
                    put_entry(s, "saveDataDat", 8'h20, $urandom, $urandom);
                end
            end
            jump = ($urandom_range(4) == 0) ? int'($urandom_range(510, 1)) : -1;
            run_scan(jump, -1, -1, int'($urandom_range(30)));
        end

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
